// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard and forwarding logic.
// Revision 1.0
`default_nettype none

package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Forward-select encodings shared with the ALU and RF forwarding selectors
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_DM  = 2'b10;

    localparam int MDU_LAT_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/mdu_busy_timer.sv
// mdu_busy_timer: tracks MDU occupancy from an accepted start strobe to HI/LO valid.
// Revision 1.0
`default_nettype none

module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(MDU_LAT - 1);
                    end
                end
                BUSY: begin
                    // Last occupied cycle: HI/LO valid is flagged on the following cycle
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / MDU-occupancy stall and taken-branch flush control for ID.
// Revision 1.0
`default_nettype none

module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = 5,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              ID_UseRs,
    input  logic              ID_UseRt,
    input  logic              ID_IsMdu,
    input  logic              ID_ReadHiLo,
    input  logic              ID_EX_MemRd,
    input  logic              ID_EX_RfWr,
    input  logic [4:0]        ID_EX_rw,
    input  logic              EX_Taken,
    output logic              PcWr,
    output logic              IF_ID_Wr,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              MduStart,
    output logic              MduBusy,
    output logic              MduDone,
    output logic [PERF_W-1:0] StallCycles
);

    logic load_use;
    logic mdu_haz;
    logic stall;

    // Register 0 is hardwired, so a load targeting it never creates a dependency
    assign load_use = ID_EX_MemRd && ID_EX_RfWr && (ID_EX_rw != 5'd0) &&
                      ((ID_UseRs && (ID_rs == ID_EX_rw)) ||
                       (ID_UseRt && (ID_rt == ID_EX_rw)));

    assign mdu_haz = MduBusy && (ID_IsMdu || ID_ReadHiLo);
    assign stall   = (load_use || mdu_haz) && !EX_Taken;

    always_comb begin
        PcWr        = 1'b1;
        IF_ID_Wr    = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (!rst_n) begin
            PcWr        = 1'b0;
            IF_ID_Wr    = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (EX_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall) begin
            PcWr        = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    assign MduStart = rst_n && ID_IsMdu && !stall && !EX_Taken && !MduBusy;

    mdu_busy_timer #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_busy_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MduStart),
        .busy  (MduBusy),
        .done  (MduDone)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCycles <= '0;
        end else if (!PcWr && (StallCycles != '1)) begin
            StallCycles <= StallCycles + PERF_W'(1);
        end
    end

endmodule

`default_nettype wire
